// File: rtl/interpolate.sv
// Sample-rate interpolator with stb/ack handshakes on both sides.
// Each accepted input sample produces M output samples: the sample repeated
// M times (hold mode) or the sample followed by M-1 zeros (zero-stuff mode).
// The last phase of a sample can accept the next sample in the same cycle,
// so a continuous stream runs at one output per cycle with no bubbles.
module interpolate #(
    parameter int W    = 32,
    parameter int M    = 4,
    parameter bit ZERO = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_dat,
    input  logic         s_stb,
    output logic         s_ack,
    output logic [W-1:0] m_dat,
    output logic         m_stb,
    input  logic         m_ack
);

    // Phase counter is at least one bit wide so M=1 still has a legal vector.
    localparam int            PW   = (M > 1) ? $clog2(M) : 1;
    localparam logic [PW-1:0] LAST = PW'(M - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] phase;
    logic [W-1:0]  held;
    logic          last;
    logic          s_xfer;
    logic          m_xfer;

    // m_stb is the decoded state register, so it is glitch-free and registered.
    assign m_stb = (state == EMIT);
    assign last  = (phase == LAST);

    // NOTE: s_ack is combinational from m_ack on the final phase; this is what
    // lets a new sample load in the same cycle the last output leaves, giving
    // full throughput without a bubble. It is never a path from s_dat to m_dat.
    assign s_ack  = !m_stb || (last && m_ack);
    assign s_xfer = s_stb && s_ack;
    assign m_xfer = m_stb && m_ack;

    // Sample load, phase advance and output data generation.
    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            phase <= '0;
            held  <= '0;
            m_dat <= '0;
        end else if (s_xfer) begin
            // Idle load, or back-to-back reload on the final phase.
            state <= EMIT;
            phase <= '0;
            held  <= s_dat;
            m_dat <= s_dat;
        end else if (m_xfer) begin
            if (last) begin
                state <= IDLE;
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
                m_dat <= ZERO ? '0 : held;
            end
        end
    end

endmodule

// File: tb/tb_interpolate.sv
// Scoreboard bench for interpolate. Stimulus pushes expected output samples
// into per-instance queues; independent monitors pop and compare on every
// output transfer. Instance "a" (W=32, M=4, hold) runs directed handshake,
// backpressure and reset scenarios; a generate loop covers zero-stuff M=4,
// hold M=3 and M=1 in both modes with full-rate streams.
module tb_interpolate;

    int vectors     = 0;
    int miscompares = 0;

    logic clk;
    logic a_rst;
    logic g_rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Instance a: W=32, M=4, hold mode
    // ------------------------------------------------------------------
    logic [31:0] a_s_dat;
    logic        a_s_stb;
    logic        a_s_ack;
    logic [31:0] a_m_dat;
    logic        a_m_stb;
    logic        a_m_ack;

    interpolate #(.W(32), .M(4), .ZERO(1'b0)) u_a (
        .clk  (clk),
        .rst  (a_rst),
        .s_dat(a_s_dat),
        .s_stb(a_s_stb),
        .s_ack(a_s_ack),
        .m_dat(a_m_dat),
        .m_stb(a_m_stb),
        .m_ack(a_m_ack)
    );

    logic [31:0] a_q[$];
    bit          a_stall = 1'b0;
    logic [31:0] a_prev  = '0;

    // Monitor for instance a: pops on every transfer and checks stall stability.
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (!a_rst) begin
            a_stall = 1'b0;
        end else begin
            if (a_stall) begin
                check("a_stall_stb", a_m_stb, 1);
                check("a_stall_dat", a_m_dat, a_prev);
            end
            if (a_m_stb && a_m_ack) begin
                exp_v = (a_q.size() > 0) ? a_q.pop_front() : 'x;
                check("a_out", a_m_dat, exp_v);
            end
            a_stall = a_m_stb && !a_m_ack;
            a_prev  = a_m_dat;
        end
    end

    task automatic a_step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic [31:0] v, input int n);
        for (int k = 0; k < n; k++) a_q.push_back(v);
    endtask

    // ------------------------------------------------------------------
    // Streaming instances: zero M=4, hold M=3, hold M=1, zero M=1
    // ------------------------------------------------------------------
    localparam int CFG_M[4]     = '{4, 3, 1, 1};
    localparam bit CFG_Z[4]     = '{1'b1, 1'b0, 1'b0, 1'b1};
    localparam int CFG_START[4] = '{5, 0, 0, 0};
    localparam int CFG_STEP[4]  = '{4, 1, 1, 1};

    bit g_done[4];

    for (genvar g = 0; g < 4; g++) begin : gen_cfg
        localparam int MM = CFG_M[g];
        localparam bit ZZ = CFG_Z[g];
        localparam int ST = CFG_START[g];
        localparam int SP = CFG_STEP[g];

        logic [31:0] s_dat;
        logic        s_stb;
        logic        s_ack;
        logic [31:0] m_dat;
        logic        m_stb;
        logic        m_ack;

        interpolate #(.W(32), .M(MM), .ZERO(ZZ)) u_dut (
            .clk  (clk),
            .rst  (g_rst),
            .s_dat(s_dat),
            .s_stb(s_stb),
            .s_ack(s_ack),
            .m_dat(m_dat),
            .m_stb(m_stb),
            .m_ack(m_ack)
        );

        logic [31:0] q[$];
        int          n_out = 0;
        int          gaps  = 0;

        // Monitor: scoreboard compare, phase range, and no bubbles mid-stream.
        always @(negedge clk) begin
            logic [31:0] exp_v;
            if (g_rst) begin
                if (m_stb) check($sformatf("g%0d_phase_range", g), (u_dut.phase < MM), 1);
                if (m_stb && m_ack) begin
                    exp_v = (q.size() > 0) ? q.pop_front() : 'x;
                    check($sformatf("g%0d_out", g), m_dat, exp_v);
                    n_out++;
                end else if (n_out > 0 && n_out < 8 * MM) begin
                    gaps++;
                end
            end
        end

        // Stream eight samples with s_stb and m_ack held high.
        initial begin
            int w;
            logic [31:0] v;
            s_stb = 1'b0;
            s_dat = '0;
            m_ack = 1'b1;
            @(posedge g_rst);
            @(posedge clk);
            #1;
            check($sformatf("g%0d_idle_ack", g), s_ack, 1);
            s_stb = 1'b1;
            for (int i = 0; i < 8; i++) begin
                v     = 32'(ST + SP * i);
                s_dat = v;
                q.push_back(v);
                for (int k = 1; k < MM; k++) q.push_back(ZZ ? 32'd0 : v);
                w = 0;
                while (!s_ack && w < 20) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                check($sformatf("g%0d_accept_spacing", g), w, (i == 0) ? 0 : MM - 1);
                @(posedge clk);
                #1;
                if (i == 0) begin
                    check($sformatf("g%0d_latency_stb", g), m_stb, 1);
                    check($sformatf("g%0d_latency_dat", g), m_dat, v);
                end
            end
            s_stb = 1'b0;
            s_dat = '1;
            repeat (MM + 2) @(posedge clk);
            #1;
            check($sformatf("g%0d_drained", g), m_stb, 0);
            check($sformatf("g%0d_queue_empty", g), q.size(), 0);
            check($sformatf("g%0d_out_count", g), n_out, 8 * MM);
            check($sformatf("g%0d_no_bubbles", g), gaps, 0);
            g_done[g] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence on instance a, then final wrap-up
    // ------------------------------------------------------------------
    initial begin
        int t;
        int w;
        bit pat[7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        a_rst   = 1'b0;
        g_rst   = 1'b0;
        a_s_dat = '0;
        a_s_stb = 1'b0;
        a_m_ack = 1'b1;
        #1;
        check("a_reset_stb", a_m_stb, 0);
        check("a_reset_dat", a_m_dat, 0);
        check("a_reset_ack", a_s_ack, 1);
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b1;
        g_rst = 1'b1;
        a_step();

        // Hold mode: 7 -> 7,7,7,7; s_ack low for three cycles, high on the fourth.
        a_s_stb = 1'b1;
        a_s_dat = 32'd7;
        a_push(32'd7, 4);
        check("a_idle_ack", a_s_ack, 1);
        a_step();
        a_s_stb = 1'b0;
        a_s_dat = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            check("a_hold_stb", a_m_stb, 1);
            check("a_hold_sack", a_s_ack, (k == 3));
            a_step();
        end
        check("a_hold_done", a_m_stb, 0);

        // Backpressure: 3 held through a 1,0,0,1,1,0,1 ack pattern; 4 waits.
        a_s_stb = 1'b1;
        a_s_dat = 32'd3;
        a_push(32'd3, 4);
        a_push(32'd4, 4);
        a_step();
        a_s_dat = 32'd4;
        t = 0;
        for (int i = 0; i < 7; i++) begin
            a_m_ack = pat[i];
            #1;
            check("a_bp_sack", a_s_ack, (t == 3) && pat[i]);
            if (pat[i]) t++;
            @(posedge clk);
            #1;
        end
        a_s_stb = 1'b0;
        a_m_ack = 1'b1;
        check("a_bp_second_loaded", a_m_dat, 32'd4);
        repeat (4) a_step();
        check("a_bp_done", a_m_stb, 0);

        // Reset mid-stream: 0xA5 flushed after two outputs, then 1 x4.
        a_s_stb = 1'b1;
        a_s_dat = 32'hA5;
        a_push(32'hA5, 2);
        a_step();
        a_s_stb = 1'b0;
        repeat (2) a_step();
        a_rst = 1'b0;
        #1;
        check("a_rst_stb", a_m_stb, 0);
        check("a_rst_dat", a_m_dat, 0);
        check("a_rst_ack", a_s_ack, 1);
        check("a_rst_consumed", a_q.size(), 0);
        repeat (2) a_step();
        a_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_step();
            check("a_post_rst_quiet", a_m_stb, 0);
        end
        a_s_stb = 1'b1;
        a_s_dat = 32'd1;
        a_push(32'd1, 4);
        a_step();
        a_s_stb = 1'b0;
        repeat (5) a_step();
        check("a_post_rst_done", a_m_stb, 0);
        check("a_queue_empty", a_q.size(), 0);

        w = 0;
        while (!(g_done[0] && g_done[1] && g_done[2] && g_done[3]) && w < 2000) begin
            @(posedge clk);
            w++;
        end
        check("streams_done", (g_done[0] && g_done[1] && g_done[2] && g_done[3]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interpolate.md
INTERPOLATE -- requirements
Module: interpolate

Interface
REQ-001 W, 32: data width in bits; SHALL be >= 1.
REQ-002 M, 4: interpolation factor (output samples per input sample); SHALL be >= 1, not required to be a power of two.
REQ-003 ZERO, 0: fill mode; 0 = hold (repeat input M times), 1 = zero-stuff (input once, then M-1 zeros).
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 s_dat  input  W  input sample.
REQ-007 s_stb  input  1  input sample valid.
REQ-008 s_ack  output  1  input sample accepted.
REQ-009 m_dat  output  W  output sample.
REQ-010 m_stb  output  1  output sample valid.
REQ-011 m_ack  input  1  output sample accepted by downstream.

Function
REQ-012 Handshake: a transfer SHALL occur on a port in every cycle where its stb and ack are both high at the rising edge of clk.
REQ-013 Once m_stb is asserted, the block SHALL hold m_stb and m_dat stable until the transfer completes.
REQ-014 The block SHALL NOT depend on a low-to-high ack transition; ack may be held high continuously.
REQ-015 Internal state: held sample register (W bits); phase counter of max(1, clog2(M)) bits, range 0..M-1; output-valid flag.
REQ-016 States: IDLE (m_stb=0) and EMIT (m_stb=1, phase p).
REQ-017 IDLE: s_ack SHALL be 1. An input transfer SHALL load the sample, set phase=0 and enter EMIT on the next cycle.
REQ-018 EMIT with p < M-1: s_ack SHALL be 0. An output transfer SHALL increment p.
REQ-019 EMIT with p = M-1: s_ack SHALL equal m_ack (combinational).
REQ-020 At p = M-1, output transfer with simultaneous input transfer: the block SHALL load the new sample, set p=0 and stay in EMIT (no bubble).
REQ-021 At p = M-1, output transfer with no input transfer: the block SHALL return to IDLE.
REQ-022 m_dat in hold mode SHALL equal the held sample in every phase.
REQ-023 m_dat in zero mode SHALL equal the held sample at p=0 and all-zeros at p=1..M-1.
REQ-024 Latency: the first output of a sample SHALL be valid one cycle after that sample's input transfer (registered; no combinational s_dat-to-m_dat path).
REQ-025 Throughput: with m_ack held high and s_stb held high, the block SHALL accept exactly one input every M cycles and emit one output every cycle.
REQ-026 M=1: the block SHALL behave as a one-deep registered pipeline stage, with s_ack = !m_stb || m_ack, in both modes.
REQ-027 s_dat SHALL be ignored whenever no input transfer occurs.
REQ-028 Phase wrap: p SHALL never exceed M-1, including when M is not a power of two.

Reset
REQ-029 While rst=0: m_stb=0, m_dat=0, phase=0, held sample=0, and s_ack=1 (IDLE).
REQ-030 Reset asserted mid-EMIT SHALL discard the held sample and remaining phases immediately, without waiting for a clk edge.
REQ-031 After rst deasserts, the first accepted input SHALL start at phase 0.
REQ-032 No output SHALL appear after reset until a new input transfer occurs.

Verification
REQ-033 Hold mode, W=32, M=4, m_ack=1: input 7 -> m_dat 7,7,7,7 on four consecutive cycles; s_ack=0 during the first three and 1 during the fourth.
REQ-034 Zero mode, W=32, M=4: inputs 5, 9 back-to-back -> 5,0,0,0,9,0,0,0 on eight consecutive cycles with no bubble between samples.
REQ-035 Backpressure, hold mode: input 3, m_ack toggled 1,0,0,1,1,0,1 -> exactly four transfers of 3; m_dat and m_stb stable while m_ack=0; s_stb held high with a second sample 4 that is accepted only in the cycle of the fourth transfer.
REQ-036 Reset mid-stream: input 0xA5, rst pulsed low after two outputs -> m_stb=0 immediately; after release, input 1 -> outputs 1,1,1,1 and no further 0xA5.
REQ-037 Non-power-of-two M=3, hold mode, eight inputs 0..7 with m_ack=1 -> 24 outputs, each value repeated exactly three times in order; phase never reaches 3.
REQ-038 M=1 in both modes: inputs 0..7 streamed with m_ack=1 -> outputs 0..7, one cycle of latency, full rate.
